// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the MEM stage and its data RAM.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Reserved size behaves as a word access.
  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return (off != 2'b00);
    endcase
  endfunction

  // Byte-enable for a store at the given byte offset.
  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data across all lanes; the mask picks the live ones.
  function automatic logic [31:0] store_lanes(input size_e sz, input logic [31:0] d);
    case (sz)
      SZ_BYTE: return {4{d[7:0]}};
      SZ_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Shift the addressed lane down and extend it; word loads ignore sign_ext.
  function automatic logic [31:0] load_extract(input logic [31:0] q, input size_e sz,
                                               input logic [1:0] off, input logic sx);
    logic [31:0] sh;
    sh = q >> {off, 3'b000};
    case (sz)
      SZ_BYTE: return sx ? {{24{sh[7]}}, sh[7:0]} : {24'b0, sh[7:0]};
      SZ_HALF: return sx ? {{16{sh[15]}}, sh[15:0]} : {16'b0, sh[15:0]};
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port synchronous data RAM with byte write-enables and registered read data.
module data_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write selected lanes, or register a read; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: data RAM access with wait states, alignment check,
// load extension and the MEM/WB output register.
module mem_stage_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic              valid_out,
  output logic [DATA_W-1:0] rdata_out,
  output logic [DATA_W-1:0] alu_out,
  output logic              misalign
);
  import mem_pkg::*;

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_W-1:0] a);
    logic [ADDR_W-3:0] w;
    w = a[ADDR_W-1:2];
    return IDX_W'(32'(w) % 32'(DEPTH));
  endfunction

  state_e            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;

  logic [DATA_W-1:0] lat_alu, lat_alu_nxt;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nxt;
  size_e             lat_size, lat_size_nxt;
  logic              lat_sign, lat_sign_nxt;
  logic              lat_load, lat_load_nxt;

  logic              valid_q, valid_nxt;
  logic [DATA_W-1:0] alu_q, alu_nxt;
  logic              mis_q, mis_nxt;
  logic              ld_q, ld_nxt;
  size_e             ld_size, ld_size_nxt;
  logic [1:0]        ld_off, ld_off_nxt;
  logic              ld_sign, ld_sign_nxt;

  logic              ram_en, ram_we;
  logic [3:0]        ram_be;
  logic [IDX_W-1:0]  ram_addr;
  logic [DATA_W-1:0] ram_wd, ram_q;

  size_e             in_size;
  logic              in_op, in_mis;

  assign in_size = size_e'(size);
  assign in_op   = mem_read | mem_write;
  assign in_mis  = misaligned(in_size, alu_res[1:0]);

  // Next-state, latch and output-register computation.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    lat_alu_nxt   = lat_alu;
    lat_wdata_nxt = lat_wdata;
    lat_size_nxt  = lat_size;
    lat_sign_nxt  = lat_sign;
    lat_load_nxt  = lat_load;
    valid_nxt     = 1'b0;
    alu_nxt       = alu_q;
    mis_nxt       = 1'b0;
    ld_nxt        = ld_q;
    ld_size_nxt   = ld_size;
    ld_off_nxt    = ld_off;
    ld_sign_nxt   = ld_sign;
    ram_en        = 1'b0;
    ram_we        = 1'b0;
    ram_be        = lane_mask(lat_size, lat_alu[1:0]);
    ram_addr      = word_idx(lat_alu);
    ram_wd        = store_lanes(lat_size, lat_wdata);

    case (state)
      ST_IDLE: begin
        if (!flush && valid_in) begin
          if (!in_op) begin
            valid_nxt = 1'b1;
            alu_nxt   = alu_res;
            ld_nxt    = 1'b0;
          end else if (in_mis) begin
            valid_nxt = 1'b1;
            mis_nxt   = 1'b1;
            alu_nxt   = alu_res;
            ld_nxt    = 1'b0;
          end else if (WAIT_CYCLES == 0) begin
            ram_en      = 1'b1;
            ram_we      = !mem_read;
            ram_be      = lane_mask(in_size, alu_res[1:0]);
            ram_addr    = word_idx(alu_res);
            ram_wd      = store_lanes(in_size, wdata);
            valid_nxt   = 1'b1;
            alu_nxt     = alu_res;
            ld_nxt      = mem_read;
            ld_size_nxt = in_size;
            ld_off_nxt  = alu_res[1:0];
            ld_sign_nxt = sign_ext;
          end else begin
            lat_alu_nxt   = alu_res;
            lat_wdata_nxt = wdata;
            lat_size_nxt  = in_size;
            lat_sign_nxt  = sign_ext;
            lat_load_nxt  = mem_read;
            cnt_nxt       = CNT_INIT;
            state_nxt     = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
        if (!flush) begin
          ram_en      = 1'b1;
          ram_we      = !lat_load;
          valid_nxt   = 1'b1;
          alu_nxt     = lat_alu;
          ld_nxt      = lat_load;
          ld_size_nxt = lat_size;
          ld_off_nxt  = lat_alu[1:0];
          ld_sign_nxt = lat_sign;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, latched operands and MEM/WB register update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_alu   <= '0;
      lat_wdata <= '0;
      lat_size  <= SZ_WORD;
      lat_sign  <= 1'b0;
      lat_load  <= 1'b0;
      valid_q   <= 1'b0;
      alu_q     <= '0;
      mis_q     <= 1'b0;
      ld_q      <= 1'b0;
      ld_size   <= SZ_WORD;
      ld_off    <= '0;
      ld_sign   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      lat_alu   <= lat_alu_nxt;
      lat_wdata <= lat_wdata_nxt;
      lat_size  <= lat_size_nxt;
      lat_sign  <= lat_sign_nxt;
      lat_load  <= lat_load_nxt;
      valid_q   <= valid_nxt;
      alu_q     <= alu_nxt;
      mis_q     <= mis_nxt;
      ld_q      <= ld_nxt;
      ld_size   <= ld_size_nxt;
      ld_off    <= ld_off_nxt;
      ld_sign   <= ld_sign_nxt;
    end
  end

  data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en && rst),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wd),
    .rdata (ram_q)
  );

  // The RAM read register doubles as the load-data stage of MEM/WB: the
  // extraction controls are registered alongside it, so rdata_out changes
  // only at the completing edge and is zero for anything but a load.
  assign rdata_out = ld_q ? load_extract(ram_q, ld_size, ld_off, ld_sign) : '0;
  assign stall     = (state != ST_IDLE);
  assign valid_out = valid_q;
  assign alu_out   = alu_q;
  assign misalign  = mis_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed self-checking bench for mem_stage_ctrl (WAIT_CYCLES=2 and =0 builds).
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in, mem_read, mem_write, sign_ext;
  logic [1:0]  size;
  logic [31:0] alu_res, wdata;

  logic        a_stall, a_valid, a_mis;
  logic [31:0] a_rdata, a_alu;
  logic        b_stall, b_valid, b_mis;
  logic [31:0] b_rdata, b_alu;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .sign_ext(sign_ext),
    .alu_res(alu_res), .wdata(wdata),
    .stall(a_stall), .valid_out(a_valid), .rdata_out(a_rdata),
    .alu_out(a_alu), .misalign(a_mis)
  );

  mem_stage_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .sign_ext(sign_ext),
    .alu_res(alu_res), .wdata(wdata),
    .stall(b_stall), .valid_out(b_valid), .rdata_out(b_rdata),
    .alu_out(b_alu), .misalign(b_mis)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic sx, input logic [31:0] addr, input logic [31:0] wd);
    valid_in  = v;
    mem_read  = rd;
    mem_write = wr;
    size      = sz;
    sign_ext  = sx;
    alu_res   = addr;
    wdata     = wd;
  endtask

  // One aligned access on the wait-state build: expects 3 stall cycles and one valid pulse.
  task automatic do_access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                           input logic sx, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] exp_rdata);
    int   n;
    logic bad;
    drive(1'b1, rd, wr, sz, sx, addr, wd);
    tick;
    n   = 0;
    bad = 1'b0;
    while (a_stall === 1'b1 && n < 20) begin
      if (a_valid !== 1'b0) bad = 1'b1;
      n++;
      tick;
    end
    check({tag, " stall_cycles"}, 32'(n), 32'd3);
    check1({tag, " valid_during_stall"}, bad, 1'b0);
    check1({tag, " valid"}, a_valid, 1'b1);
    check({tag, " rdata"}, a_rdata, exp_rdata);
    check({tag, " alu"}, a_alu, addr);
    valid_in = 1'b0;
    tick;
    check1({tag, " valid_once"}, a_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    tick;
    tick;
    check1("rst valid", a_valid, 1'b0);
    check("rst rdata", a_rdata, 32'h0);
    check("rst alu", a_alu, 32'h0);
    check1("rst mis", a_mis, 1'b0);
    check1("rst stall", a_stall, 1'b0);
    rst = 1'b1;
    tick;

    do_access("st_word", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0010, 32'hDEADBEEF, 32'h0);
    do_access("ld_word", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0, 32'hDEADBEEF);
    do_access("st_byte", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0013, 32'h00000080, 32'h0);
    do_access("ld_byte_sx", 1'b1, 1'b0, 2'b00, 1'b1, 32'h0013, 32'h0, 32'hFFFFFF80);
    do_access("ld_byte_zx", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0013, 32'h0, 32'h00000080);
    do_access("ld_word2", 1'b1, 1'b0, 2'b10, 1'b1, 32'h0010, 32'h0, 32'h80ADBEEF);

    // misaligned half load
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0011, 32'h0);
    tick;
    check1("mis_half mis", a_mis, 1'b1);
    check1("mis_half valid", a_valid, 1'b1);
    check("mis_half rdata", a_rdata, 32'h0);
    check1("mis_half stall", a_stall, 1'b0);
    valid_in = 1'b0;
    tick;
    check1("mis_half mis_once", a_mis, 1'b0);

    // misaligned word store must not touch RAM
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0012, 32'hFFFFFFFF);
    tick;
    check1("mis_word mis", a_mis, 1'b1);
    check1("mis_word stall", a_stall, 1'b0);
    valid_in = 1'b0;
    tick;
    do_access("ld_after_mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0010, 32'h0, 32'h80ADBEEF);

    // flush during second ACCESS cycle of a store
    do_access("st_prior", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0020, 32'hCAFEF00D, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0020, 32'h12345678);
    tick;
    tick;
    check1("flush pre stall", a_stall, 1'b1);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    valid_in = 1'b0;
    check1("flush stall", a_stall, 1'b0);
    check1("flush valid", a_valid, 1'b0);
    tick;
    do_access("ld_after_flush", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0020, 32'h0, 32'hCAFEF00D);

    // flush beats acceptance in IDLE
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0020, 32'h0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    valid_in = 1'b0;
    check1("flush_idle valid", a_valid, 1'b0);
    check1("flush_idle stall", a_stall, 1'b0);

    // back-to-back non-memory ops
    drive(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h00000042, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check1("nonmem valid", a_valid, 1'b1);
      check("nonmem alu", a_alu, 32'h42);
      check("nonmem rdata", a_rdata, 32'h0);
      check1("nonmem stall", a_stall, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h00000099, 32'h0);
    tick;
    check1("idle valid", a_valid, 1'b0);
    check("idle alu_hold", a_alu, 32'h42);

    // reset during ACCESS
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0020, 32'h11111111);
    tick;
    check1("rst_mid pre stall", a_stall, 1'b1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    valid_in = 1'b0;
    check1("rst_mid stall", a_stall, 1'b0);
    check1("rst_mid valid", a_valid, 1'b0);
    check("rst_mid alu", a_alu, 32'h0);
    check("rst_mid rdata", a_rdata, 32'h0);
    check1("rst_mid mis", a_mis, 1'b0);
    tick;
    do_access("ld_after_rst", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0020, 32'h0, 32'hCAFEF00D);

    // word index wraps modulo DEPTH: 0x1010 -> index 4 (same as 0x0010)
    do_access("ld_wrap", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 32'h80ADBEEF);

    // zero-wait-state build: single-cycle round trip, no stall
    drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h0040, 32'hA5A51234);
    tick;
    check1("w0 st valid", b_valid, 1'b1);
    check1("w0 st stall", b_stall, 1'b0);
    check("w0 st rdata", b_rdata, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h0040, 32'h0);
    tick;
    check1("w0 ld valid", b_valid, 1'b1);
    check1("w0 ld stall", b_stall, 1'b0);
    check("w0 ld rdata", b_rdata, 32'hA5A51234);
    drive(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 32'h0042, 32'h0);
    tick;
    check("w0 ldh rdata", b_rdata, 32'hFFFFA5A5);
    check("w0 ldh alu", b_alu, 32'h0042);
    valid_in = 1'b0;
    tick;
    check1("w0 idle valid", b_valid, 1'b0);
    check("w0 idle rdata_hold", b_rdata, 32'hFFFFA5A5);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Parametrised MEM pipeline stage for the 32-bit core, sitting between the EX/MEM and MEM/WB boundaries.
- Owns the data RAM. Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Models a multi-cycle memory through a wait-state counter. Stalls the pipeline during an access and raises a misalignment flag.
- Registers its outputs as the MEM/WB pipeline register, with flush support.

Parameters:
- DATA_W, 32: datapath width; must be 32.
- ADDR_W, 16: byte-address bits used from the ALU result.
- DEPTH, 1024: RAM depth in DATA_W words; word index is addr[ADDR_W-1:2] mod DEPTH.
- WAIT_CYCLES, 2: extra cycles per memory access (0..15); 0 gives single-cycle access.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-low reset
- flush  in  1  kill the instruction currently in the stage
- valid_in  in  1  EX/MEM holds a valid instruction
- mem_read  in  1  load
- mem_write  in  1  store (mem_read and mem_write both high is illegal; treated as a load)
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- sign_ext  in  1  1 = sign-extend loads, 0 = zero-extend
- alu_res  in  DATA_W  effective address or ALU result
- wdata  in  DATA_W  store data, right-aligned
- stall  out  1  hold upstream stages; combinational from state
- valid_out  out  1  MEM/WB valid
- rdata_out  out  DATA_W  extended load data
- alu_out  out  DATA_W  registered alu_res
- misalign  out  1  registered, one cycle, with the faulting instruction's valid_out

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, wait counter=0, valid_out=0, rdata_out=0, alu_out=0, misalign=0, stall=0. RAM contents are not reset.
- Misalignment rules:
  - half: addr[0]=1 is misaligned.
  - word or reserved: addr[1:0]≠0 is misaligned.
  - A misaligned access performs no RAM read or write. It completes in one cycle with misalign=1, valid_out=1 and rdata_out=0.
- Non-memory instruction (valid_in=1, no read/write): one-cycle latency. Next edge gives valid_out=1, alu_out=alu_res, rdata_out=0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: an aligned memory op with valid_in=1 and WAIT_CYCLES>0 latches address, data, size, sign_ext and op, loads counter=WAIT_CYCLES-1, goes to ACCESS, and sets valid_out=0.
  - IDLE with WAIT_CYCLES=0: the access completes in place (RAM read or write at this edge) and valid_out=1 at the next edge. No stall.
  - ACCESS: stall=1. The counter decrements each cycle. When counter=0, go to DONE.
  - DONE: stall=1. The RAM operation executes at this edge. Outputs are registered with valid_out=1. Return to IDLE; stall drops the following cycle.
  - Total stall for an aligned access is WAIT_CYCLES+1 cycles. Result is visible WAIT_CYCLES+1 cycles after acceptance.
- Store: byte lanes are chosen by addr[1:0] (byte) or addr[1] (half). Only the selected lanes are written; other lanes are preserved. rdata_out=0.
- Load: the selected lane is shifted down and extended per sign_ext. For a word load, sign_ext is ignored.
- Flush:
  - In IDLE: the next valid_out=0 and no memory access starts.
  - In ACCESS or DONE: abort, return to IDLE and drop stall next cycle. A pending store is NOT written; a load produces valid_out=0.
  - Flush has priority over acceptance in the same cycle.
- While stall=1, upstream inputs are held by the pipeline. The block ignores input changes during ACCESS/DONE because it uses latched copies.
- valid_in=0 in IDLE: valid_out=0, alu_out and rdata_out unchanged.
- Reset mid-access: the FSM returns to IDLE, no write occurs and stall drops on the following cycle.
- Address wrap: a word index beyond DEPTH wraps modulo DEPTH, with no error.

Decomposition:
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - state encoding ST_IDLE/ST_ACCESS/ST_DONE;
  - functions for lane mask generation and load extraction/extension.
- One sub-module, data_ram: single-port synchronous RAM, DEPTH x DATA_W, with 4-bit byte write-enable, read data registered. The FSM, alignment check and extension logic stay in mem_stage_ctrl.

Test Plan:
- WAIT_CYCLES=2: word store 0xDEADBEEF to 0x0010, then word load from 0x0010. Each access gives stall high for 3 cycles; the load gives rdata_out=0xDEADBEEF, valid_out=1 exactly once.
- Byte store 0x80 to 0x0013, then loads from 0x0013: with sign_ext=1, rdata_out=0xFFFFFF80; with sign_ext=0, 0x00000080. A word load from 0x0010 gives 0x80ADBEEF.
- Half load from 0x0011 → misalign=1, valid_out=1, rdata_out=0, no stall. A word store to 0x0012 leaves RAM unchanged.
- Flush asserted in the second ACCESS cycle of a store of 0x12345678 to 0x0020. stall drops next cycle, valid_out=0, and a later load from 0x0020 returns its prior value.
- Non-memory op with alu_res=0x00000042, back-to-back over 4 cycles → valid_out=1 each cycle, alu_out=0x42, stall=0 throughout.
- rst=0 asserted during ACCESS → next cycle all outputs 0 and state IDLE. Rebuild with WAIT_CYCLES=0: load/store round trip with no stall and one-cycle latency.
